// File: rtl/prog_counter.sv
// Registered up/down counter over the window [cnt_ini, cnt_rst-1] with load,
// one-shot halt (done), one-cycle tick on each terminal event and a saturating wrap count.
module prog_counter #(
  parameter int NBITS = 32,
  parameter int WBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             oneshot,
  input  logic             load,
  input  logic [NBITS-1:0] load_val,
  input  logic [NBITS-1:0] cnt_ini,
  input  logic [NBITS-1:0] cnt_rst,
  input  logic             wclr,
  output logic [NBITS-1:0] q,
  output logic             tick,
  output logic             done,
  output logic [WBITS-1:0] wraps
);

  typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

  localparam logic [NBITS-1:0] ONE  = NBITS'(1);
  localparam logic [WBITS-1:0] WONE = WBITS'(1);
  localparam logic [WBITS-1:0] WMAX = '1;

  state_t           state, state_nxt;
  logic [NBITS-1:0] q_nxt, q_inc, q_dec, top;
  logic [WBITS-1:0] wraps_nxt;
  logic             step, term, tick_nxt;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      q     <= '0;
      tick  <= 1'b0;
      wraps <= '0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      tick  <= tick_nxt;
      wraps <= wraps_nxt;
    end
  end

  // next-state logic; load wins over stepping, DONE freezes q
  always_comb begin
    q_inc     = q + ONE;
    q_dec     = q - ONE;
    top       = cnt_rst - ONE;
    step      = (state == RUN) && en && !load;
    term      = step && (dir ? (q_inc == cnt_rst) : (q == cnt_ini));
    tick_nxt  = term;
    state_nxt = state;
    q_nxt     = q;
    if (load) begin
      q_nxt     = load_val;
      state_nxt = RUN;
    end else if (step) begin
      if (term) begin
        q_nxt = dir ? cnt_ini : top;
        if (oneshot) state_nxt = DONE;
      end else begin
        q_nxt = dir ? q_inc : q_dec;
      end
    end
    // a clear coinciding with a terminal event still records that event
    if (wclr)
      wraps_nxt = term ? WONE : '0;
    else if (term && wraps != WMAX)
      wraps_nxt = wraps + WONE;
    else
      wraps_nxt = wraps;
  end

  // outputs
  always_comb begin
    done = (state == DONE);
  end

endmodule
